// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg: register word indices and FSM states shared by the interrupt controller.
package intr_ctrl_pkg;
    localparam logic [1:0] PEND_IDX  = 2'd0;
    localparam logic [1:0] EN_IDX    = 2'd1;
    localparam logic [1:0] MODE_IDX  = 2'd2;
    localparam logic [1:0] CLAIM_IDX = 2'd3;
    typedef enum logic [1:0] {IDLE, ASSERT, IN_SERVICE} intr_state_e;
endpackage

// File: rtl/intr_prio_enc.sv
// intr_prio_enc: fixed-priority encoder, lowest request index wins; ID = index + 1, 0 if none.
module intr_prio_enc
    import intr_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8,
    localparam int ID_W = $clog2(NUM_SRC + 1)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [ID_W-1:0]    id
);
    always_comb begin
        id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (req[i]) id = ID_W'(i + 1);
    end
endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: memory-mapped interrupt controller with level/edge sources and claim/complete handshake.
// Define INTR_CTRL_SYNC_EN to put a 2-flop synchronizer in front of every source line.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int NUM_SRC = 8,
    localparam int ID_W = $clog2(NUM_SRC + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               cs,
    input  logic               we,
    input  logic               re,
    input  logic [1:0]         addr_i,
    input  logic [DW-1:0]      wdata_i,
    output logic [DW-1:0]      rdata_o,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o
);
    logic [NUM_SRC-1:0] pend, en, mode, cond, prev, req, rise, w1c, claim_clr;
    logic [ID_W-1:0] win_id, claimed_id;
    intr_state_e state, state_n;
    logic wr, rd, claim, complete, unused_wdata;
`ifdef INTR_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1, sync_q2;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= src_i;
            sync_q2 <= sync_q1;
        end
    assign cond = sync_q2;
`else
    assign cond = src_i;
`endif
    assign wr = cs & we;
    assign rd = cs & re & ~we;
    assign req = pend & en;
    assign rise = cond & ~prev & mode;
    assign w1c = (wr && addr_i == PEND_IDX) ? wdata_i[NUM_SRC-1:0] & mode : '0;
    assign claim = rd && addr_i == CLAIM_IDX && state == ASSERT && |req;
    assign complete = wr && addr_i == CLAIM_IDX && state == IN_SERVICE && wdata_i[ID_W-1:0] == claimed_id;
    assign unused_wdata = ^wdata_i;
    assign rdata_o = !(cs && re) ? '0 :
                     addr_i == PEND_IDX ? DW'(pend) :
                     addr_i == EN_IDX   ? DW'(en)   :
                     addr_i == MODE_IDX ? DW'(mode) : DW'(win_id);
    intr_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (.req(req), .id(win_id));
    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < NUM_SRC; i++)
            claim_clr[i] = claim && win_id == ID_W'(i + 1);
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = |req ? ASSERT : IDLE;
            ASSERT:     state_n = !(|req) ? IDLE : claim ? IN_SERVICE : ASSERT;
            IN_SERVICE: state_n = complete ? IDLE : IN_SERVICE;
            default:    state_n = IDLE;
        endcase
    end
    // edge bits: a fresh rise beats a same-cycle claim or W1C; level bits mirror the source
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            pend       <= '0;
            en         <= '0;
            mode       <= '0;
            prev       <= '0;
            state      <= IDLE;
            claimed_id <= '0;
            irq_o      <= 1'b0;
            irq_id_o   <= '0;
        end else begin
            pend       <= (mode & (rise | (pend & ~(w1c | claim_clr)))) | (~mode & cond);
            en         <= (wr && addr_i == EN_IDX) ? wdata_i[NUM_SRC-1:0] : en;
            mode       <= (wr && addr_i == MODE_IDX) ? wdata_i[NUM_SRC-1:0] : mode;
            prev       <= cond;
            state      <= state_n;
            claimed_id <= claim ? win_id : claimed_id;
            irq_o      <= state_n == ASSERT;
            irq_id_o   <= win_id;
        end
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_intr_ctrl;
    localparam int NS = 8;
    localparam int DW = 32;
    localparam int ID_W = 4;
`ifdef INTR_CTRL_SYNC_EN
    localparam int SYNC_LAT = 3;
`else
    localparam int SYNC_LAT = 1;
`endif
    logic clk_i, rst_i, cs, we, re, irq_o;
    logic [NS-1:0] src_i;
    logic [1:0] addr_i;
    logic [DW-1:0] wdata_i, rdata_o;
    logic [ID_W-1:0] irq_id_o;
    int errors = 0;
    int checks = 0;
    logic [NS-1:0] m_pend, m_en, m_mode, m_s1, m_s2, m_prev;
    int m_state, m_claimed, m_id;
    bit m_irq;

    intr_ctrl #(.DW(DW), .NUM_SRC(NS)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .src_i(src_i), .cs(cs), .we(we), .re(re),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .irq_o(irq_o), .irq_id_o(irq_id_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic m_reset();
        m_pend = '0; m_en = '0; m_mode = '0; m_s1 = '0; m_s2 = '0; m_prev = '0;
        m_state = 0; m_claimed = 0; m_id = 0; m_irq = 1'b0;
    endtask

    function automatic int m_win();
        for (int i = 0; i < NS; i++)
            if (m_pend[i] && m_en[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [DW-1:0] m_rdata();
        if (!(cs && re)) return '0;
        case (addr_i)
            2'd0: return DW'(m_pend);
            2'd1: return DW'(m_en);
            2'd2: return DW'(m_mode);
            default: return DW'(m_win());
        endcase
    endfunction

    // state: 0 idle, 1 asserting, 2 in service
    task automatic m_step();
        logic [NS-1:0] cond, npend;
        int win, nstate;
        bit w, r, claim, complete;
        cond = (SYNC_LAT == 3) ? m_s2 : src_i;
        win = m_win();
        w = cs && we;
        r = cs && re && !we;
        claim = r && addr_i == 2'd3 && m_state == 1 && win != 0;
        complete = w && addr_i == 2'd3 && m_state == 2 && int'(wdata_i[ID_W-1:0]) == m_claimed;
        for (int i = 0; i < NS; i++)
            if (m_mode[i])
                npend[i] = (cond[i] && !m_prev[i]) ||
                           (m_pend[i] && !(claim && win == i + 1) && !(w && addr_i == 2'd0 && wdata_i[i]));
            else
                npend[i] = cond[i];
        if (m_state == 0) nstate = (win != 0) ? 1 : 0;
        else if (m_state == 1) nstate = (win == 0) ? 0 : (claim ? 2 : 1);
        else nstate = complete ? 0 : 2;
        if (claim) m_claimed = win;
        m_irq = (nstate == 1);
        m_id = win;
        if (w && addr_i == 2'd1) m_en = wdata_i[NS-1:0];
        if (w && addr_i == 2'd2) m_mode = wdata_i[NS-1:0];
        m_prev = cond;
        m_s2 = m_s1;
        m_s1 = src_i;
        m_pend = npend;
        m_state = nstate;
    endtask

    task automatic tick();
        @(posedge clk_i);
        m_step();
        #1;
        cs = 1'b0; we = 1'b0; re = 1'b0;
    endtask

    task automatic set_rd(input int a);
        cs = 1'b1; re = 1'b1; we = 1'b0; addr_i = 2'(a);
        #1;
    endtask

    task automatic wr_reg(input int a, input logic [DW-1:0] d);
        cs = 1'b1; we = 1'b1; re = 1'b0; addr_i = 2'(a); wdata_i = d;
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; cs = 1'b0; we = 1'b0; re = 1'b0; addr_i = '0; wdata_i = '0; src_i = '0;
        m_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b want 0", irq_o); end
        checks++; if (irq_id_o !== '0) begin errors++; $display("FAIL reset_id: got %0d want 0", irq_id_o); end
        for (int a = 0; a < 4; a++) begin
            set_rd(a);
            checks++; if (rdata_o !== '0) begin errors++; $display("FAIL reset_reg%0d: got %h want 0", a, rdata_o); end
        end
        cs = 1'b0; re = 1'b0;
    endtask

    task automatic test_edge_claim();
        wr_reg(1, 32'h04);
        wr_reg(2, 32'h04);
        src_i = 8'h04;
        tick();
        src_i = '0;
        repeat (SYNC_LAT - 1) tick();
        set_rd(0);
        checks++; if (rdata_o !== 32'h04) begin errors++; $display("FAIL edge_pend: got %h want 04", rdata_o); end
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd3) begin errors++; $display("FAIL edge_irq: got irq=%0b id=%0d want 1/3", irq_o, irq_id_o); end
        set_rd(3);
        checks++; if (rdata_o !== 32'd3) begin errors++; $display("FAIL edge_claim: got %0d want 3", rdata_o); end
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL edge_drop: got %0b want 0", irq_o); end
        set_rd(0);
        checks++; if (rdata_o !== '0) begin errors++; $display("FAIL edge_pend_clr: got %h want 0", rdata_o); end
        wr_reg(3, 32'd3);
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL edge_done: got %0b want 0", irq_o); end
    endtask

    task automatic test_wrong_id();
        wr_reg(2, 32'h0);
        wr_reg(1, 32'h04);
        src_i = 8'h04;
        repeat (SYNC_LAT + 1) tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd3) begin errors++; $display("FAIL wid_irq: got irq=%0b id=%0d want 1/3", irq_o, irq_id_o); end
        set_rd(3);
        checks++; if (rdata_o !== 32'd3) begin errors++; $display("FAIL wid_claim: got %0d want 3", rdata_o); end
        tick();
        wr_reg(3, 32'd4);
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL wid_ignored: got %0b want 0", irq_o); end
        wr_reg(3, 32'd3);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL wid_early: got %0b want 0", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd3) begin errors++; $display("FAIL wid_reassert: got irq=%0b id=%0d want 1/3", irq_o, irq_id_o); end
        src_i = '0;
        repeat (SYNC_LAT + 1) tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL wid_level_drop: got %0b want 0", irq_o); end
    endtask

    task automatic test_priority();
        wr_reg(1, 32'hFF);
        src_i = 8'h22;
        repeat (SYNC_LAT + 1) tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd2) begin errors++; $display("FAIL prio_irq: got irq=%0b id=%0d want 1/2", irq_o, irq_id_o); end
        set_rd(3);
        checks++; if (rdata_o !== 32'd2) begin errors++; $display("FAIL prio_claim: got %0d want 2", rdata_o); end
        tick();
        wr_reg(3, 32'd2);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL prio_gap: got %0b want 0", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd2) begin errors++; $display("FAIL prio_rearm: got irq=%0b id=%0d want 1/2", irq_o, irq_id_o); end
    endtask

    task automatic test_disable();
        wr_reg(1, 32'h0);
        set_rd(3);
        checks++; if (rdata_o !== '0) begin errors++; $display("FAIL dis_claim: got %0d want 0", rdata_o); end
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL dis_irq: got %0b want 0", irq_o); end
        src_i = '0;
        repeat (SYNC_LAT) tick();
    endtask

    task automatic test_collision();
        wr_reg(2, 32'h01);
        wr_reg(1, 32'h01);
        src_i = 8'h01;
        tick();
        src_i = '0;
        repeat (SYNC_LAT) tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd1) begin errors++; $display("FAIL col_irq: got irq=%0b id=%0d want 1/1", irq_o, irq_id_o); end
        src_i = 8'h01;
        repeat (SYNC_LAT - 1) begin
            tick();
            src_i = '0;
        end
        set_rd(3);
        checks++; if (rdata_o !== 32'd1) begin errors++; $display("FAIL col_claim: got %0d want 1", rdata_o); end
        tick();
        src_i = '0;
        set_rd(0);
        checks++; if (rdata_o !== 32'h01 || irq_o !== 1'b0) begin errors++; $display("FAIL col_pend: got pend=%h irq=%0b want 01/0", rdata_o, irq_o); end
        wr_reg(3, 32'd1);
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd1) begin errors++; $display("FAIL col_reassert: got irq=%0b id=%0d want 1/1", irq_o, irq_id_o); end
        wr_reg(0, 32'h01);
        tick();
        set_rd(0);
        checks++; if (rdata_o !== '0 || irq_o !== 1'b0) begin errors++; $display("FAIL col_w1c: got pend=%h irq=%0b want 0/0", rdata_o, irq_o); end
        cs = 1'b0; re = 1'b0;
    endtask

    task automatic test_async_reset();
        wr_reg(2, 32'h0);
        wr_reg(1, 32'h01);
        src_i = 8'h01;
        repeat (SYNC_LAT + 1) tick();
        set_rd(3);
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL ar_service: got %0b want 0", irq_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (irq_o !== 1'b0 || irq_id_o !== '0) begin errors++; $display("FAIL ar_outputs: got irq=%0b id=%0d want 0/0", irq_o, irq_id_o); end
        set_rd(0);
        checks++; if (rdata_o !== '0) begin errors++; $display("FAIL ar_pend: got %h want 0", rdata_o); end
        set_rd(1);
        checks++; if (rdata_o !== '0) begin errors++; $display("FAIL ar_en: got %h want 0", rdata_o); end
        cs = 1'b0; re = 1'b0;
        rst_i = 1'b0;
        m_reset();
        wr_reg(1, 32'h01);
        repeat (SYNC_LAT + 1) tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd1) begin errors++; $display("FAIL ar_idle: got irq=%0b id=%0d want 1/1", irq_o, irq_id_o); end
        src_i = '0;
        repeat (SYNC_LAT + 1) tick();
    endtask

    task automatic test_random();
        int op;
        logic [DW-1:0] exp;
        wr_reg(2, DW'($urandom_range(0, 255)));
        wr_reg(1, DW'($urandom_range(0, 255)));
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) src_i = NS'($urandom);
            op = $urandom_range(0, 9);
            cs = op < 6;
            we = op < 2;
            re = op >= 2 && op < 6;
            addr_i = 2'($urandom_range(0, 3));
            wdata_i = (addr_i == 2'd3) ? DW'($urandom_range(0, 9)) : DW'($urandom);
            #1;
            exp = m_rdata();
            checks++; if (rdata_o !== exp) begin errors++; $display("FAIL rnd_rdata@%0d: got %h want %h", n, rdata_o, exp); end
            tick();
            checks++; if (irq_o !== m_irq || irq_id_o !== ID_W'(m_id)) begin errors++; $display("FAIL rnd_irq@%0d: got irq=%0b id=%0d want %0b/%0d", n, irq_o, irq_id_o, m_irq, m_id); end
        end
    endtask

    initial begin
        test_reset();
        test_edge_claim();
        test_wrong_id();
        test_priority();
        test_disable();
        test_collision();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
